mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single MIO memory port between the IF stage (instruction fetch, read-only) and the
//  MEM stage (lw/sw) of the pipelined CPU. Sequences each access over the MIO_ready handshake and
//  stalls the losing or waiting stage. Times out hung accesses and reports a bus error to the CP0 logic.
//  It sits between the IF/MEM stages and the external memory/IO bus.
// PARAMETERS
//  DATA_W   32  data/address width
//  TIMEOUT  15  max cycles in a grant state without MIO_ready before a bus error (1..2^TO_W-1)
//  TO_W     4   timeout counter width
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  if_req     in   1       IF stage wants an instruction word
//  if_addr    in   DATA_W  fetch address (PC)
//  if_flush   in   1       branch/jump/exception: discard any in-flight fetch
//  if_rdata   out  DATA_W  fetched instruction, valid while if_done=1
//  if_done    out  1       one-cycle pulse: fetch complete
//  if_stall   out  1       if_req && !if_done
//  mem_req    in   1       MEM stage lw/sw request
//  mem_we     in   1       1=sw, 0=lw
//  mem_addr   in   DATA_W  data address (ALU output)
//  mem_wdata  in   DATA_W  store data
//  mem_rdata  out  DATA_W  load data, valid while mem_done=1
//  mem_done   out  1       one-cycle pulse: data access complete
//  mem_stall  out  1       mem_req && !mem_done
//  bus_req    out  1       request to memory bus (registered)
//  bus_we     out  1       write enable (registered)
//  bus_addr   out  DATA_W  bus address (registered)
//  bus_wdata  out  DATA_W  bus write data (registered)
//  bus_rdata  in   DATA_W  bus read data, sampled when MIO_ready=1
//  MIO_ready  in   1       bus completes the access this cycle
//  bus_err    out  1       one-cycle pulse: access timed out
//  bus_err_src out 1       1=error on MEM access, 0=on IF access; held until next bus_err
// BEHAVIOUR
//  - States: IDLE, GRANT_IF, GRANT_MEM. Reset: IDLE; every output 0; cnt=0; discard=0.
//  - IDLE: mem_req -> GRANT_MEM (MEM has fixed priority), else if_req -> GRANT_IF; latch
//    addr/we/wdata into bus_* regs. For IF grant: bus_we=0, bus_wdata=0.
//  - A requester whose *_done is high this cycle has its req ignored in that cycle (no re-issue);
//    the other requester's req is still arbitrated.
//  - GRANT_x: bus_req=1, bus_* held stable. cnt increments each cycle.
//    MIO_ready=1 -> capture bus_rdata into x_rdata (lw/fetch only; sw leaves mem_rdata unchanged),
//    pulse x_done next cycle, bus_req=0, -> IDLE.
//  - Latency: req in IDLE at cycle N -> bus_req N+1; MIO_ready at N+1 -> done and data at N+2;
//    stall high N..N+1. Each extra MIO wait cycle adds one cycle.
//  - Timeout: cnt==TIMEOUT with MIO_ready=0 -> bus_err pulse and x_done pulse next cycle,
//    x_rdata=0, bus_err_src set, bus_req=0, -> IDLE. MIO_ready on the same cycle wins
//    (normal completion, no error).
//  - if_flush in GRANT_IF sets discard; access still completes on the bus (not cancellable),
//    but if_done is suppressed and if_rdata keeps its old value.
//  - if_flush in IDLE or in the if_done cycle: that cycle's if_req is not granted. discard clears on leaving GRANT_IF.
//  - if_flush has no effect on MEM accesses; a timed-out discarded fetch still raises bus_err.
//  - rst mid-access: next cycle IDLE, bus_req=0, no done/err pulse; the bus must tolerate
//    abandonment.
//  - Back-to-back: minimum one IDLE cycle between grants (the done cycle).
// TESTING
//  - IF only, MIO_ready 1 cycle after bus_req: if_req@0, addr=0x40, rdata=0x8C010004 ->
//    bus_req@1, if_done=1 and if_rdata=0x8C010004 @2, if_stall=1 @0..1.
//  - Simultaneous if_req/mem_req(sw 0x10<-0xDEADBEEF)@0 -> MEM granted @1 (bus_we=1);
//    mem_done@2; IF granted @3 with bus_addr=PC; if_done@4.
//  - MIO_ready held low: GRANT_MEM lw with TIMEOUT=15 -> bus_err=1, bus_err_src=1 and
//    mem_done=1 with mem_rdata=0, 16 cycles after grant; state IDLE afterwards.
//  - if_flush during GRANT_IF with 3 wait cycles -> no if_done, if_rdata unchanged; new
//    if_req (new PC) granted on the cycle after completion.
//  - rst asserted in GRANT_MEM with MIO_ready low -> bus_req=0 next cycle, no mem_done, state IDLE;
//    later lw completes normally.
//  - mem_req held through its done cycle -> exactly one bus transaction issued (no duplicate).

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory/IO bus port between the instruction fetch and the data access stages.
// MEM has fixed priority; each access runs over MIO_ready with a hang timeout that raises bus_err.
module mem_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              MIO_ready,
    output logic              bus_err,
    output logic              bus_err_src
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] GRANT_IF  = 2'd1;
    localparam logic [1:0] GRANT_MEM = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [TO_W-1:0]   cnt_reg;
    logic              discard_reg;
    logic [DATA_W-1:0] if_rdata_reg, mem_rdata_reg;
    logic              if_done_reg, mem_done_reg;
    logic              bus_req_reg, bus_we_reg;
    logic [DATA_W-1:0] bus_addr_reg, bus_wdata_reg;
    logic              bus_err_reg, bus_err_src_reg;

    logic grant_mem, grant_if, in_grant, timed_out, finish, if_drop;

    // A requester in its done cycle is ignored so a held request is not re-issued.
    assign grant_mem = (state_reg == IDLE) && mem_req && !mem_done_reg;
    assign grant_if  = (state_reg == IDLE) && !grant_mem && if_req && !if_done_reg && !if_flush;
    assign in_grant  = (state_reg != IDLE);
    assign timed_out = in_grant && !MIO_ready && (cnt_reg == TO_W'(TIMEOUT));
    assign finish    = in_grant && (MIO_ready || timed_out);
    assign if_drop   = discard_reg || if_flush;

    always_comb begin
        state_next = state_reg;
        if (grant_mem)
            state_next = GRANT_MEM;
        else if (grant_if)
            state_next = GRANT_IF;
        else if (finish)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            discard_reg     <= 1'b0;
            if_rdata_reg    <= '0;
            mem_rdata_reg   <= '0;
            if_done_reg     <= 1'b0;
            mem_done_reg    <= 1'b0;
            bus_req_reg     <= 1'b0;
            bus_we_reg      <= 1'b0;
            bus_addr_reg    <= '0;
            bus_wdata_reg   <= '0;
            bus_err_reg     <= 1'b0;
            bus_err_src_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            if_done_reg  <= 1'b0;
            mem_done_reg <= 1'b0;
            bus_err_reg  <= 1'b0;

            if (grant_mem || grant_if) begin
                bus_req_reg   <= 1'b1;
                bus_we_reg    <= grant_mem && mem_we;
                bus_addr_reg  <= grant_mem ? mem_addr : if_addr;
                bus_wdata_reg <= grant_mem ? mem_wdata : '0;
                cnt_reg       <= '0;
                discard_reg   <= 1'b0;
            end else if (in_grant) begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (state_reg == GRANT_IF && if_flush)
                discard_reg <= 1'b1;

            if (finish) begin
                bus_req_reg <= 1'b0;
                discard_reg <= 1'b0;
                bus_err_reg <= timed_out;
                if (timed_out)
                    bus_err_src_reg <= (state_reg == GRANT_MEM);
                if (state_reg == GRANT_MEM) begin
                    mem_done_reg <= 1'b1;
                    if (timed_out)
                        mem_rdata_reg <= '0;
                    else if (!bus_we_reg)
                        mem_rdata_reg <= bus_rdata;
                end else if (!if_drop) begin
                    // A flushed fetch still finishes on the bus but is never reported.
                    if_done_reg  <= 1'b1;
                    if_rdata_reg <= timed_out ? '0 : bus_rdata;
                end
            end
        end
    end

    assign if_rdata    = if_rdata_reg;
    assign if_done     = if_done_reg;
    assign if_stall    = if_req && !if_done_reg;
    assign mem_rdata   = mem_rdata_reg;
    assign mem_done    = mem_done_reg;
    assign mem_stall   = mem_req && !mem_done_reg;
    assign bus_req     = bus_req_reg;
    assign bus_we      = bus_we_reg;
    assign bus_addr    = bus_addr_reg;
    assign bus_wdata   = bus_wdata_reg;
    assign bus_err     = bus_err_reg;
    assign bus_err_src = bus_err_src_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised transaction-level bench for mem_port_arbiter: expected timing is derived from
// the request cycle, the number of wait cycles and the timeout limit.
module tb_mem_port_arbiter;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, mem_req, mem_we, MIO_ready;
    logic [DW-1:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [DW-1:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic          if_done, if_stall, mem_done, mem_stall;
    logic          bus_req, bus_we, bus_err, bus_err_src;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_if_rdata  = '0;
    logic [31:0] exp_mem_rdata = '0;
    logic [31:0] exp_src       = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DW), .TIMEOUT(TO), .TO_W(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .MIO_ready(MIO_ready),
        .bus_err(bus_err), .bus_err_src(bus_err_src)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = fetch, 1 = lw, 2 = sw. waits > TO means the bus never answers.
    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input bit flush, input bit keep_req);
        bit          to;
        bit          exp_done;
        int          end_j;
        int          flush_j;
        logic [31:0] rd;
        to      = (waits > TO);
        end_j   = to ? TO : waits;
        flush_j = flush ? int'($urandom_range(0, end_j)) : -1;
        rd      = $urandom;
        tick();
        if (kind == 0) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = (kind == 2);
            mem_addr  = addr;
            mem_wdata = wdata;
        end
        #1;
        check_val("stall_req_cycle", 32'(kind == 0 ? if_stall : mem_stall), 32'd1);
        check_val("bus_req_idle", 32'(bus_req), 32'd0);
        for (int j = 0; j <= end_j; j++) begin
            tick();
            if (j == 0) begin
                check_val("bus_addr", bus_addr, addr);
                check_val("bus_we", 32'(bus_we), 32'(kind == 2));
                check_val("bus_wdata", bus_wdata, kind == 0 ? 32'd0 : wdata);
            end
            check_val("bus_req_grant", 32'(bus_req), 32'd1);
            check_val("done_in_grant", 32'(if_done | mem_done), 32'd0);
            check_val("stall_in_grant", 32'(kind == 0 ? if_stall : mem_stall), 32'd1);
            MIO_ready = (!to && j == waits);
            bus_rdata = MIO_ready ? rd : $urandom;
            if_flush  = (j == flush_j);
        end
        tick();
        MIO_ready = 1'b0;
        if_flush  = 1'b0;
        exp_done  = !(kind == 0 && flush);
        if (exp_done) begin
            if (kind == 0) exp_if_rdata = to ? 32'd0 : rd;
            else if (kind == 1 || to) exp_mem_rdata = to ? 32'd0 : rd;
        end
        if (to) exp_src = 32'(kind != 0);
        check_val("if_done", 32'(if_done), 32'(kind == 0 && exp_done));
        check_val("mem_done", 32'(mem_done), 32'(kind != 0));
        check_val("if_rdata", if_rdata, exp_if_rdata);
        check_val("mem_rdata", mem_rdata, exp_mem_rdata);
        check_val("bus_err", 32'(bus_err), 32'(to));
        check_val("bus_err_src", 32'(bus_err_src), exp_src);
        check_val("bus_req_done", 32'(bus_req), 32'd0);
        check_val("stall_done", 32'(kind == 0 ? if_stall : mem_stall), 32'(!exp_done));
        $display("txn kind=%0d addr=%h waits=%0d flush=%0d timeout=%0d", kind, addr, waits, flush, to);
        if (!keep_req) begin
            if_req  = 1'b0;
            mem_req = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        int          kind, waits, r;
        bit          fl;
        rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        MIO_ready = 1'b0; if_addr = '0; mem_addr = '0; mem_wdata = '0; bus_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check_val("rst_bus_req", 32'(bus_req), 32'd0);
        check_val("rst_dones", 32'({if_done, mem_done, bus_err, bus_err_src}), 32'd0);
        check_val("rst_rdata", if_rdata | mem_rdata, 32'd0);
        check_val("rst_bus_bits", bus_addr | bus_wdata | 32'(bus_we), 32'd0);

        // Plain fetch, one-cycle bus.
        run_txn(0, 32'h40, 32'd0, 0, 1'b0, 1'b0);

        // Simultaneous fetch and store: MEM wins, fetch follows after the done cycle.
        tick();
        pc = 32'h0000_0080;
        if_req = 1'b1; if_addr = pc;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hDEADBEEF;
        #1;
        check_val("sim_stalls", 32'({if_stall, mem_stall}), 32'd3);
        tick();
        check_val("sim_mem_grant", 32'({bus_req, bus_we}), 32'd3);
        check_val("sim_mem_addr", bus_addr, 32'h10);
        check_val("sim_mem_wdata", bus_wdata, 32'hDEADBEEF);
        MIO_ready = 1'b1; bus_rdata = 32'h1234_5678;
        tick();
        MIO_ready = 1'b0;
        check_val("sim_mem_done", 32'({mem_done, if_done, bus_req}), 32'b100);
        check_val("sim_sw_rdata", mem_rdata, exp_mem_rdata);
        check_val("sim_if_stall", 32'(if_stall), 32'd1);
        mem_req = 1'b0;
        tick();
        check_val("sim_if_grant", 32'({bus_req, bus_we}), 32'b10);
        check_val("sim_if_addr", bus_addr, pc);
        check_val("sim_if_wdata", bus_wdata, 32'd0);
        MIO_ready = 1'b1; bus_rdata = 32'h8C01_0004;
        tick();
        MIO_ready = 1'b0;
        exp_if_rdata = 32'h8C01_0004;
        check_val("sim_if_done", 32'(if_done), 32'd1);
        check_val("sim_if_rdata", if_rdata, exp_if_rdata);
        $display("txn simultaneous sw/fetch done");
        if_req = 1'b0;

        // Load, then timeout boundaries: ready on the last allowed cycle, then a hang.
        run_txn(1, 32'h200, 32'd0, 2, 1'b0, 1'b0);
        run_txn(1, 32'h204, 32'd0, TO, 1'b0, 1'b0);
        run_txn(1, 32'h208, 32'd0, TO + 3, 1'b0, 1'b0);
        run_txn(0, 32'h300, 32'd0, TO + 1, 1'b0, 1'b0);

        // Flushed fetch with 3 waits; the new PC held through completion is granted next.
        run_txn(0, 32'h400, 32'd0, 3, 1'b1, 1'b1);
        if_addr = 32'h500;
        tick();
        check_val("flush_regrant", 32'(bus_req), 32'd1);
        check_val("flush_new_pc", bus_addr, 32'h500);
        MIO_ready = 1'b1; bus_rdata = 32'hA5A5_0001;
        tick();
        MIO_ready = 1'b0;
        exp_if_rdata = 32'hA5A5_0001;
        check_val("flush_next_done", 32'(if_done), 32'd1);
        check_val("flush_next_rdata", if_rdata, exp_if_rdata);
        $display("txn fetch after flush done");
        if_req = 1'b0;

        // Load request held through its done cycle: no second bus transaction.
        run_txn(1, 32'h600, 32'd0, 1, 1'b0, 1'b1);
        tick();
        check_val("held_no_reissue", 32'(bus_req), 32'd0);
        mem_req = 1'b0;

        // Reset in the middle of a hung load.
        tick();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h700;
        tick();
        check_val("rst_mid_grant", 32'(bus_req), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check_val("rst_mid_bus_req", 32'(bus_req), 32'd0);
        check_val("rst_mid_pulses", 32'({mem_done, bus_err}), 32'd0);
        rst = 1'b0; mem_req = 1'b0;
        exp_if_rdata = '0; exp_mem_rdata = '0; exp_src = '0;
        tick();
        check_val("rst_mid_idle", 32'({bus_req, mem_done}), 32'd0);
        $display("txn reset mid-access done");
        run_txn(1, 32'h704, 32'd0, 1, 1'b0, 1'b0);

        // Random transactions.
        for (int i = 0; i < 40; i++) begin
            kind  = int'($urandom_range(0, 2));
            r     = int'($urandom_range(0, 9));
            waits = (r < 7) ? int'($urandom_range(0, 4)) : int'($urandom_range(TO - 1, TO + 3));
            fl    = (kind == 0) && ($urandom_range(0, 3) == 0);
            run_txn(kind, $urandom, $urandom, waits, fl, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
